// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Command characters, FSM encodings and byte classification
//               shared by the UART command decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  localparam logic [7:0] CMD_MODE  = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_TIME  = 8'h54;  // 'T'
  localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_NAK   = 8'h3F;  // '?'
  localparam logic [7:0] CASE_BIT  = 8'h20;
  localparam logic [7:0] CNT_MAX   = 8'hFF;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [ST_W-1:0] ST_DECODE   = 2'd1;
  localparam logic [ST_W-1:0] ST_ACK_WAIT = 2'd2;

  typedef enum logic [2:0] {
    CK_MODE,
    CK_TIME,
    CK_RUN,
    CK_CLEAR,
    CK_IGNORE,
    CK_INVALID
  } cmd_kind_e;

  typedef struct packed {
    logic mode;
    logic tunit;
    logic run;
    logic clear;
  } pulse_t;

  function automatic logic [7:0] fold_upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) begin
      return b & ~CASE_BIT;
    end
    return b;
  endfunction

  function automatic cmd_kind_e classify(input logic [7:0] b);
    cmd_kind_e k;
    case (fold_upper(b))
      CMD_MODE:       k = CK_MODE;
      CMD_TIME:       k = CK_TIME;
      CMD_RUN:        k = CK_RUN;
      CMD_CLEAR:      k = CK_CLEAR;
      CHR_CR, CHR_LF: k = CK_IGNORE;
      default:        k = CK_INVALID;
    endcase
    return k;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
    if (en && v != CNT_MAX) begin
      return v + 8'd1;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_decoder
// Description : Turns single-character UART commands into one-cycle control
//               pulses and optionally echoes an acknowledge byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ECHO_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic       mode_toggle_uart,
  output logic       time_toggle_uart,
  output logic       run_toggle_uart,
  output logic       clear_uart,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic [7:0] err_cnt,
  output logic [7:0] drop_cnt
);

  logic [ST_W-1:0] state_q, state_d;
  logic [7:0]      cmd_reg_q, cmd_reg_d;
  logic [7:0]      ack_q, ack_d;
  pulse_t          pulse_q, pulse_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            err_inc, drop_inc;
  cmd_kind_e       cmd_kind;

  assign cmd_kind = classify(cmd_reg_q);

  always_comb begin
    state_d    = state_q;
    cmd_reg_d  = cmd_reg_q;
    ack_d      = ack_q;
    pulse_d    = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    err_inc    = 1'b0;
    drop_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          cmd_reg_d = rx_data;
          state_d   = ST_DECODE;
        end
      end

      ST_DECODE: begin
        drop_inc = rx_valid;
        case (cmd_kind)
          CK_MODE:  pulse_d.mode  = 1'b1;
          CK_TIME:  pulse_d.tunit = 1'b1;
          CK_RUN:   pulse_d.run   = 1'b1;
          CK_CLEAR: pulse_d.clear = 1'b1;
          default:  pulse_d       = '0;
        endcase
        // Line terminators are silently consumed: no echo, no error.
        if (cmd_kind == CK_IGNORE) begin
          state_d = ST_IDLE;
        end else begin
          if (cmd_kind == CK_INVALID) begin
            err_inc = 1'b1;
            ack_d   = CHR_NAK;
          end else begin
            ack_d   = fold_upper(cmd_reg_q);
          end
          state_d = (ECHO_EN != 0) ? ST_ACK_WAIT : ST_IDLE;
        end
      end

      ST_ACK_WAIT: begin
        // A byte arriving on the return edge is still a drop.
        drop_inc = rx_valid;
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = ack_q;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    err_cnt_d  = sat_inc(err_cnt_q, err_inc);
    drop_cnt_d = sat_inc(drop_cnt_q, drop_inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_reg_q  <= 8'h00;
      ack_q      <= 8'h00;
      pulse_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      err_cnt_q  <= 8'h00;
      drop_cnt_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cmd_reg_q  <= cmd_reg_d;
      ack_q      <= ack_d;
      pulse_q    <= pulse_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign mode_toggle_uart = pulse_q.mode;
  assign time_toggle_uart = pulse_q.tunit;
  assign run_toggle_uart  = pulse_q.run;
  assign clear_uart       = pulse_q.clear;
  assign tx_start         = tx_start_q;
  assign tx_data          = tx_data_q;
  assign busy             = (state_q != ST_IDLE);
  assign err_cnt          = err_cnt_q;
  assign drop_cnt         = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_decoder
// Description : Self-checking bench for uart_cmd_decoder (echo on and off).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

  localparam int N = 1500;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data, rx_data0;
  logic       rx_valid, rx_valid0;
  logic       tx_busy, tx_busy0;
  logic       mode_o, time_o, run_o, clear_o, txs, bsy;
  logic [7:0] txd, errc, dropc;
  logic       mode0, time0, run0, clear0, txs0, bsy0;
  logic [7:0] txd0, errc0, dropc0;

  int n_vec = 0;
  int n_bad = 0;
  int m_err;
  logic [7:0] m_txd;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.ECHO_EN(1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .mode_toggle_uart(mode_o), .time_toggle_uart(time_o), .run_toggle_uart(run_o),
    .clear_uart(clear_o), .tx_start(txs), .tx_data(txd), .busy(bsy),
    .err_cnt(errc), .drop_cnt(dropc)
  );

  uart_cmd_decoder #(.ECHO_EN(0)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data0), .rx_valid(rx_valid0), .tx_busy(tx_busy0),
    .mode_toggle_uart(mode0), .time_toggle_uart(time0), .run_toggle_uart(run0),
    .clear_uart(clear0), .tx_start(txs0), .tx_data(txd0), .busy(bsy0),
    .err_cnt(errc0), .drop_cnt(dropc0)
  );

  wire [3:0] pulses  = {mode_o, time_o, run_o, clear_o};
  wire [3:0] pulses0 = {mode0, time0, run0, clear0};

  typedef struct {
    logic [7:0] data;
    logic [3:0] pulse;
    logic       echo;
    logic [7:0] ack;
    logic       err;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    rx_valid0 = 1'b0; rx_data0 = 8'h00; tx_busy0 = 1'b0;
    tick();
    rst = 1'b0;
    m_err = 0;
    m_txd = 8'h00;
  endtask

  // One byte on an idle decoder with the transmitter free.
  task automatic apply_vec(input vec_t v, input string tag);
    rx_data = v.data; rx_valid = 1'b1; tx_busy = 1'b0;
    tick();
    rx_valid = 1'b0; rx_data = 8'hFF;
    chk($sformatf("%s/accept_busy", tag), 32'(bsy), 32'd1);
    chk($sformatf("%s/accept_pulse", tag), 32'(pulses), 32'd0);
    tick();
    if (v.err && m_err < 255) m_err++;
    chk($sformatf("%s/pulse", tag), 32'(pulses), 32'(v.pulse));
    chk($sformatf("%s/early_txs", tag), 32'(txs), 32'd0);
    chk($sformatf("%s/err_cnt", tag), 32'(errc), 32'(m_err));
    chk($sformatf("%s/busy_decode", tag), 32'(bsy), 32'(v.echo));
    tick();
    if (v.echo) m_txd = v.ack;
    chk($sformatf("%s/pulse_gone", tag), 32'(pulses), 32'd0);
    chk($sformatf("%s/tx_start", tag), 32'(txs), 32'(v.echo));
    chk($sformatf("%s/tx_data", tag), 32'(txd), 32'(m_txd));
    chk($sformatf("%s/busy_end", tag), 32'(bsy), 32'd0);
    tick();
    chk($sformatf("%s/tx_start_off", tag), 32'(txs), 32'd0);
    chk($sformatf("%s/tx_data_hold", tag), 32'(txd), 32'(m_txd));
  endtask

  // Reference behaviour: command letters by pulse position, case-insensitive.
  function automatic void ref_cmd(input logic [7:0] b, output logic [3:0] pulse,
                                  output logic ignore, output logic [7:0] ack);
    string letters = "MTRC";
    pulse = 4'b0000;
    ignore = (b == 8'h0D) || (b == 8'h0A);
    ack = 8'h3F;
    for (int p = 0; p < 4; p++) begin
      if (b == letters[p] || b == (letters[p] + 8'd32)) begin
        pulse = 4'b1000 >> p;
        ack = letters[p];
      end
    end
  endfunction

  logic       rv [N];
  logic [7:0] rd [N];
  logic       rb [N];
  logic [3:0] e_pulse [N];
  logic       e_txs [N];
  logic [7:0] e_txd [N];
  logic       e_busy [N];
  logic       e_errinc [N];
  logic       e_dropinc [N];
  logic [7:0] e_ack_at [N];
  int         e_err [N];
  int         e_drop [N];

  task automatic random_phase();
    logic [7:0] pool [13];
    logic [3:0] pl;
    logic       ign;
    logic [7:0] ack;
    int free, j, ce, cd;
    logic [7:0] cur;
    pool = '{8'h4D, 8'h6D, 8'h54, 8'h74, 8'h52, 8'h72, 8'h43, 8'h63,
             8'h0D, 8'h0A, 8'h41, 8'h3F, 8'h00};
    for (int i = 0; i < N; i++) begin
      rv[i] = (i < N - 40) && ($urandom_range(0, 99) < 35);
      j = int'($urandom_range(0, 13));
      rd[i] = (j == 13) ? 8'($urandom) : pool[j];
      rb[i] = (i < N - 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      e_pulse[i] = 4'b0; e_txs[i] = 1'b0; e_busy[i] = 1'b0;
      e_errinc[i] = 1'b0; e_dropinc[i] = 1'b0; e_ack_at[i] = 8'h00;
    end
    free = 0;
    for (int i = 0; i < N; i++) begin
      if (rv[i]) begin
        if (i >= free) begin
          ref_cmd(rd[i], pl, ign, ack);
          e_pulse[i+1] = pl;
          e_errinc[i+1] = !ign && (pl == 4'b0);
          if (ign) begin
            j = i + 1;
          end else begin
            j = i + 2;
            while (j < N && rb[j]) j++;
            e_txs[j] = 1'b1;
            e_ack_at[j] = ack;
          end
          for (int e = i; e < j; e++) e_busy[e] = 1'b1;
          free = j + 1;
        end else begin
          e_dropinc[i] = 1'b1;
        end
      end
    end
    ce = 0; cd = 0; cur = m_txd;
    for (int i = 0; i < N; i++) begin
      if (e_errinc[i] && ce < 255) ce++;
      if (e_dropinc[i] && cd < 255) cd++;
      if (e_txs[i]) cur = e_ack_at[i];
      e_err[i] = ce; e_drop[i] = cd; e_txd[i] = cur;
    end
    for (int i = 0; i < N; i++) begin
      rx_valid = rv[i]; rx_data = rd[i]; tx_busy = rb[i];
      tick();
      chk($sformatf("rnd%0d/pulse", i), 32'(pulses), 32'(e_pulse[i]));
      chk($sformatf("rnd%0d/tx_start", i), 32'(txs), 32'(e_txs[i]));
      chk($sformatf("rnd%0d/tx_data", i), 32'(txd), 32'(e_txd[i]));
      chk($sformatf("rnd%0d/busy", i), 32'(bsy), 32'(e_busy[i]));
      chk($sformatf("rnd%0d/err_cnt", i), 32'(errc), 32'(e_err[i]));
      chk($sformatf("rnd%0d/drop_cnt", i), 32'(dropc), 32'(e_drop[i]));
    end
    rx_valid = 1'b0; tx_busy = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{8'h6D, 4'b1000, 1'b1, 8'h4D, 1'b0};
    tbl[1]  = '{8'h4D, 4'b1000, 1'b1, 8'h4D, 1'b0};
    tbl[2]  = '{8'h74, 4'b0100, 1'b1, 8'h54, 1'b0};
    tbl[3]  = '{8'h54, 4'b0100, 1'b1, 8'h54, 1'b0};
    tbl[4]  = '{8'h72, 4'b0010, 1'b1, 8'h52, 1'b0};
    tbl[5]  = '{8'h52, 4'b0010, 1'b1, 8'h52, 1'b0};
    tbl[6]  = '{8'h63, 4'b0001, 1'b1, 8'h43, 1'b0};
    tbl[7]  = '{8'h0D, 4'b0000, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{8'h43, 4'b0001, 1'b1, 8'h43, 1'b0};
    tbl[9]  = '{8'h0A, 4'b0000, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{8'h41, 4'b0000, 1'b1, 8'h3F, 1'b1};
    tbl[11] = '{8'h7A, 4'b0000, 1'b1, 8'h3F, 1'b1};

    // Reset values while reset is held.
    rst = 1'b1;
    rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    rx_valid0 = 1'b0; rx_data0 = 8'h00; tx_busy0 = 1'b0;
    #2;
    chk("reset/pulses", 32'(pulses), 32'd0);
    chk("reset/tx", 32'({txs, txd}), 32'd0);
    chk("reset/busy", 32'(bsy), 32'd0);
    chk("reset/counters", 32'({errc, dropc}), 32'd0);
    chk("reset/echo_off", 32'({pulses0, txs0, bsy0, txd0, errc0, dropc0}), 32'd0);

    do_reset();
    for (int i = 0; i < 12; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

    // Saturation of the error counter.
    do_reset();
    for (int i = 0; i < 300; i++) apply_vec(tbl[10], "errsat");
    chk("errsat/final", 32'(errc), 32'd255);

    // Long transmitter busy with a second byte landing in ACK_WAIT.
    do_reset();
    for (int e = 0; e <= 21; e++) begin
      rx_valid = (e == 0) || (e == 3);
      rx_data  = (e == 0) ? 8'h54 : 8'h58;
      tx_busy  = (e < 20);
      tick();
      chk($sformatf("busy20/e%0d_pulse", e), 32'(pulses), (e == 1) ? 32'h4 : 32'h0);
      chk($sformatf("busy20/e%0d_txs", e), 32'(txs), 32'(e == 20));
    end
    rx_valid = 1'b0;
    chk("busy20/tx_data", 32'(txd), 32'h54);
    chk("busy20/drop_cnt", 32'(dropc), 32'd1);
    chk("busy20/err_cnt", 32'(errc), 32'd0);
    chk("busy20/busy", 32'(bsy), 32'd0);

    // Asynchronous reset while waiting for the transmitter.
    do_reset();
    tx_busy = 1'b1;
    rx_data = 8'h5A; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    chk("abort/pre_err", 32'(errc), 32'd1);
    chk("abort/pre_drop", 32'(dropc), 32'd1);
    chk("abort/pre_busy", 32'(bsy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort/busy", 32'(bsy), 32'd0);
    chk("abort/counters", 32'({errc, dropc}), 32'd0);
    chk("abort/tx_data", 32'(txd), 32'd0);
    tick();
    rst = 1'b0;
    tx_busy = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk($sformatf("abort/e%0d_quiet", e), 32'({pulses, txs, bsy}), 32'd0);
    end

    // Echo disabled: pulse only, decoder free again right after DECODE.
    rx_data0 = 8'h72; rx_valid0 = 1'b1;
    tick();
    rx_valid0 = 1'b0;
    chk("noecho/accept_busy", 32'(bsy0), 32'd1);
    tick();
    chk("noecho/pulse", 32'(pulses0), 32'h2);
    chk("noecho/busy_k1", 32'(bsy0), 32'd0);
    chk("noecho/txs_k1", 32'(txs0), 32'd0);
    for (int e = 0; e < 4; e++) begin
      tick();
      chk($sformatf("noecho/e%0d_quiet", e), 32'({pulses0, txs0, bsy0}), 32'd0);
    end
    rx_data0 = 8'h21; rx_valid0 = 1'b1;
    tick();
    rx_valid0 = 1'b0;
    tick();
    tick();
    chk("noecho/err_cnt", 32'(errc0), 32'd1);
    chk("noecho/no_tx", 32'({txs0, txd0}), 32'd0);

    // Randomised traffic against the transaction-level model.
    do_reset();
    random_phase();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter ECHO_EN, default 1, meaning: 1 = acknowledge every decoded byte on the UART TX path; 0 = no TX activity.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rx_data  input  8  byte from UART receiver; valid only while rx_valid=1.
REQ-005 rx_valid  input  1  single-cycle strobe marking a new received byte.
REQ-006 tx_busy  input  1  UART transmitter busy; rises the cycle after tx_start and stays high until the byte is sent.
REQ-007 mode_toggle_uart  output  1  one-cycle pulse requesting a watch-mode toggle.
REQ-008 time_toggle_uart  output  1  one-cycle pulse requesting a time-unit toggle.
REQ-009 run_toggle_uart  output  1  one-cycle pulse requesting stopwatch run/stop.
REQ-010 clear_uart  output  1  one-cycle pulse requesting stopwatch clear.
REQ-011 tx_start  output  1  one-cycle strobe launching tx_data.
REQ-012 tx_data  output  8  acknowledge byte; held stable from tx_start until the next tx_start.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err_cnt  output  8  count of invalid command bytes, saturating at 255.
REQ-015 drop_cnt  output  8  count of bytes dropped while busy, saturating at 255.

Function
REQ-016 FSM states SHALL be IDLE, DECODE, ACK_WAIT.
REQ-017 IDLE: rx_valid=1 at edge k SHALL latch rx_data into cmd_reg and move to DECODE.
REQ-018 DECODE: edge k+1 SHALL classify cmd_reg, register the matching pulse high for exactly the cycle between edges k+1 and k+2, then move to ACK_WAIT (ECHO_EN=1) or IDLE (ECHO_EN=0).
REQ-019 Command map, case-insensitive: 'M'/'m' (0x4D/0x6D) -> mode_toggle_uart; 'T'/'t' -> time_toggle_uart; 'R'/'r' -> run_toggle_uart; 'C'/'c' -> clear_uart.
REQ-020 CR (0x0D) and LF (0x0A) SHALL be ignored: no pulse, no echo, no err_cnt change, direct return to IDLE.
REQ-021 Any other byte SHALL produce no pulse, increment err_cnt (saturating), and acknowledge with '?' (0x3F).
REQ-022 Valid-command acknowledge byte SHALL be the upper-case command character.
REQ-023 ACK_WAIT: while tx_busy=1, remain; on the first edge with tx_busy=0, assert tx_start for one cycle with tx_data = ack byte, and return to IDLE.
REQ-024 At most one pulse output SHALL be high in any cycle; all pulses SHALL be low outside the cycle defined in REQ-018.
REQ-025 rx_valid=1 in DECODE or ACK_WAIT SHALL drop the byte and increment drop_cnt (saturating); cmd_reg SHALL be unchanged.
REQ-026 rx_valid=1 on the same edge the FSM returns ACK_WAIT->IDLE SHALL count as dropped.
REQ-027 Counters SHALL hold at 255, never wrap.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, all pulse outputs 0, tx_start 0, tx_data 0x00, cmd_reg 0x00, err_cnt 0, drop_cnt 0, busy 0.
REQ-029 Reset asserted mid-operation (DECODE or ACK_WAIT) SHALL abort without emitting a pulse or tx_start, including after release.

Structure
REQ-030 Command byte constants (M, T, R, C, CR, LF, '?') and FSM state encodings SHALL live in shared package uart_cmd_pkg.
REQ-031 No sub-module; a single flat module with one FSM plus two saturating counters.

Verification
REQ-032 ECHO_EN=1, tx_busy=0, rx 'm' at edge k -> mode_toggle_uart high only between edges k+1 and k+2; tx_start one cycle later with tx_data 0x4D.
REQ-033 rx 0x41 ('A') -> no pulse, err_cnt 0->1, tx_data 0x3F; repeat 300 times -> err_cnt=255.
REQ-034 tx_busy held high 20 cycles, rx 'T' then a second byte 3 cycles later -> time_toggle_uart pulse, tx_start only after tx_busy falls, drop_cnt=1.
REQ-035 rx 0x0D then 'C' -> no activity for CR; clear_uart pulse and tx_data 0x43 for 'C'.
REQ-036 rst pulsed while in ACK_WAIT with tx_busy=1 -> no tx_start ever, state IDLE, counters 0.
REQ-037 ECHO_EN=0, rx 'r' -> run_toggle_uart pulse, tx_start never asserted, busy low by edge k+2.
